// File: rtl/mor1kx_spr_initiator_marocchino_if.sv
// Bundle of the host command/response channel, the pipeline stall handshake
// and the SPR-bus signals of the MAROCCHINO SPR initiator.
interface mor1kx_spr_initiator_marocchino_if #(
    parameter int OPTION_OPERAND_WIDTH = 32
);
    logic                            cmd_valid_i;
    logic                            cmd_ready_o;
    logic                            cmd_we_i;
    logic [15:0]                     cmd_addr_i;
    logic [OPTION_OPERAND_WIDTH-1:0] cmd_dat_i;
    logic                            rsp_valid_o;
    logic                            rsp_ready_i;
    logic [OPTION_OPERAND_WIDTH-1:0] rsp_dat_o;
    logic                            rsp_err_o;
    logic                            stall_req_o;
    logic                            pipe_stalled_i;
    logic [15:0]                     spr_bus_addr_o;
    logic                            spr_bus_stb_o;
    logic                            spr_bus_we_o;
    logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o;
    logic                            spr_bus_ack_i;
    logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i;

    // Initiator side (the design under this interface).
    modport slave (
        input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_dat_i,
        input  rsp_ready_i, pipe_stalled_i, spr_bus_ack_i, spr_bus_dat_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, stall_req_o,
        output spr_bus_addr_o, spr_bus_stb_o, spr_bus_we_o, spr_bus_dat_o
    );

    // Environment side: host agent, pipeline and SPR responders.
    modport master (
        output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_dat_i,
        output rsp_ready_i, pipe_stalled_i, spr_bus_ack_i, spr_bus_dat_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, stall_req_o,
        input  spr_bus_addr_o, spr_bus_stb_o, spr_bus_we_o, spr_bus_dat_o
    );
endinterface

// File: rtl/mor1kx_spr_initiator_marocchino.sv
// SPR-bus initiator for MAROCCHINO: takes one host read/write command, stalls
// the pipeline, runs a single SPR-bus transfer with a timeout and returns the
// result through a valid/ready response port. Every output is a register.
module mor1kx_spr_initiator_marocchino #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int TIMEOUT_CYCLES       = 16
) (
    input  logic clk,
    input  logic rst_n,
    mor1kx_spr_initiator_marocchino_if.slave spr_if
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STALL  = 3'd1,
        GAP    = 3'd2,
        ACCESS = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Last counter value before the transfer is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [OPTION_OPERAND_WIDTH-1:0] DAT_ZERO = {OPTION_OPERAND_WIDTH{1'b0}};

    state_t                          state_r;
    logic [7:0]                      cnt_r;
    logic                            cmd_ready_r;
    logic                            rsp_valid_r;
    logic [OPTION_OPERAND_WIDTH-1:0] rsp_dat_r;
    logic                            rsp_err_r;
    logic                            stall_req_r;
    logic [15:0]                     bus_addr_r;
    logic                            bus_stb_r;
    logic                            bus_we_r;
    logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_r;

    // Transfer sequencer: command capture, stall handshake, bus cycle, response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_dat_r   <= DAT_ZERO;
            rsp_err_r   <= 1'b0;
            stall_req_r <= 1'b0;
            bus_addr_r  <= 16'd0;
            bus_stb_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_dat_r   <= DAT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (spr_if.cmd_valid_i) begin
                        bus_we_r    <= spr_if.cmd_we_i;
                        bus_addr_r  <= spr_if.cmd_addr_i;
                        bus_dat_r   <= spr_if.cmd_dat_i;
                        stall_req_r <= 1'b1;
                        cmd_ready_r <= 1'b0;
                        state_r     <= STALL;
                    end
                end
                STALL: begin
                    // Waits as long as the pipeline needs to drain.
                    if (spr_if.pipe_stalled_i) begin
                        state_r <= GAP;
                    end
                end
                GAP: begin
                    // Lets the final write-back retire before the bus cycle.
                    bus_stb_r <= 1'b1;
                    cnt_r     <= 8'd0;
                    state_r   <= ACCESS;
                end
                ACCESS: begin
                    if (spr_if.spr_bus_ack_i) begin
                        rsp_dat_r   <= bus_we_r ? DAT_ZERO : spr_if.spr_bus_dat_i;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        bus_stb_r   <= 1'b0;
                        stall_req_r <= 1'b0;
                        state_r     <= RESP;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        rsp_dat_r   <= DAT_ZERO;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        bus_stb_r   <= 1'b0;
                        stall_req_r <= 1'b0;
                        state_r     <= RESP;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                RESP: begin
                    if (spr_if.rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        rsp_dat_r   <= DAT_ZERO;
                        rsp_err_r   <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a quiet idle state.
                    state_r     <= IDLE;
                    cmd_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    stall_req_r <= 1'b0;
                    bus_stb_r   <= 1'b0;
                end
            endcase
        end
    end

    assign spr_if.cmd_ready_o    = cmd_ready_r;
    assign spr_if.rsp_valid_o    = rsp_valid_r;
    assign spr_if.rsp_dat_o      = rsp_dat_r;
    assign spr_if.rsp_err_o      = rsp_err_r;
    assign spr_if.stall_req_o    = stall_req_r;
    assign spr_if.spr_bus_addr_o = bus_addr_r;
    assign spr_if.spr_bus_stb_o  = bus_stb_r;
    assign spr_if.spr_bus_we_o   = bus_we_r;
    assign spr_if.spr_bus_dat_o  = bus_dat_r;

endmodule

// File: tb/tb_mor1kx_spr_initiator_marocchino.sv
// Bench for the MAROCCHINO SPR initiator: a table of commands with hand-derived
// expected bus/response behaviour, a response scoreboard queue, and a
// reset-during-transfer sequence.
module tb_mor1kx_spr_initiator_marocchino;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mor1kx_spr_initiator_marocchino_if #(.OPTION_OPERAND_WIDTH(32)) bus_if ();

    mor1kx_spr_initiator_marocchino #(
        .OPTION_OPERAND_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .spr_if(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] dat;
        int          stall_dly;  // STALL cycles before pipe_stalled_i rises
        int          ack_at;     // stb cycle that is acked, 0 = never
        logic [31:0] rd_val;
        int          bp;         // cycles rsp_ready_i is held low
        bit          spur;       // ack driven while stb is low
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_stb;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    vec_t vecs[8];
    rsp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Issue one command and act as pipeline and SPR responder until the
    // response handshake completes, or pulse reset at stb cycle rst_at.
    task automatic run_cmd(input vec_t v, input int rst_at);
        int   stb_cnt = 0;
        int   waited  = 0;
        int   ps_cyc  = -1;
        int   guard   = 0;
        bit   done    = 1'b0;
        rsp_t e;
        while (!bus_if.cmd_ready_o && guard < 50) begin
            tick();
            guard++;
        end
        check("cmd_ready before issue", {31'd0, bus_if.cmd_ready_o}, 32'd1);
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_we_i    = v.we;
        bus_if.cmd_addr_i  = v.addr;
        bus_if.cmd_dat_i   = v.dat;
        sb_q.push_back('{v.exp_dat, v.exp_err});
        tick();
        bus_if.cmd_valid_i = 1'b0;
        bus_if.cmd_dat_i   = 32'h0;
        check("stall_req after accept", {31'd0, bus_if.stall_req_o}, 32'd1);
        check("cmd_ready after accept", {31'd0, bus_if.cmd_ready_o}, 32'd0);
        for (int g = 0; g < 300 && !done; g++) begin
            if (bus_if.spr_bus_stb_o) begin
                stb_cnt++;
                if (stb_cnt == 1) check("first stb cycle", cyc, ps_cyc + 2);
                check("bus addr", {16'd0, bus_if.spr_bus_addr_o}, {16'd0, v.addr});
                check("bus we", {31'd0, bus_if.spr_bus_we_o}, {31'd0, v.we});
                check("bus dat", bus_if.spr_bus_dat_o, v.dat);
                check("stall held in access", {31'd0, bus_if.stall_req_o}, 32'd1);
                if (rst_at != 0 && stb_cnt == rst_at) begin
                    bus_if.spr_bus_ack_i = 1'b0;
                    #1 rst_n = 1'b0;
                    #1;
                    check("rst stb", {31'd0, bus_if.spr_bus_stb_o}, 32'd0);
                    check("rst stall_req", {31'd0, bus_if.stall_req_o}, 32'd0);
                    check("rst rsp_valid", {31'd0, bus_if.rsp_valid_o}, 32'd0);
                    check("rst cmd_ready", {31'd0, bus_if.cmd_ready_o}, 32'd1);
                    sb_q.delete();
                    bus_if.pipe_stalled_i = 1'b0;
                    tick();
                    rst_n = 1'b1;
                    tick();
                    check("post-rst cmd_ready", {31'd0, bus_if.cmd_ready_o}, 32'd1);
                    check("post-rst no rsp", {31'd0, bus_if.rsp_valid_o}, 32'd0);
                    done = 1'b1;
                end else begin
                    bus_if.spr_bus_ack_i = (stb_cnt == v.ack_at);
                    bus_if.spr_bus_dat_i = v.rd_val;
                end
            end else if (bus_if.rsp_valid_o) begin
                bus_if.spr_bus_ack_i = 1'b0;
                check("stb cycles", stb_cnt, v.exp_stb);
                check("stall released", {31'd0, bus_if.stall_req_o}, 32'd0);
                check("cmd_ready in resp", {31'd0, bus_if.cmd_ready_o}, 32'd0);
                if (sb_q.size() == 0) begin
                    check("scoreboard empty", 32'd0, 32'd1);
                    e = '{32'h0, 1'b0};
                end else begin
                    e = sb_q.pop_front();
                end
                check("rsp dat", bus_if.rsp_dat_o, e.dat);
                check("rsp err", {31'd0, bus_if.rsp_err_o}, {31'd0, e.err});
                bus_if.pipe_stalled_i = 1'b0;
                for (int b = 0; b < v.bp; b++) begin
                    bus_if.cmd_valid_i = 1'b1;
                    bus_if.cmd_addr_i  = 16'h1111;
                    tick();
                    check("bp rsp_valid", {31'd0, bus_if.rsp_valid_o}, 32'd1);
                    check("bp rsp dat", bus_if.rsp_dat_o, e.dat);
                    check("bp cmd_ready", {31'd0, bus_if.cmd_ready_o}, 32'd0);
                    check("bp no new stall", {31'd0, bus_if.stall_req_o}, 32'd0);
                end
                bus_if.cmd_valid_i = 1'b0;
                bus_if.rsp_ready_i = 1'b1;
                tick();
                bus_if.rsp_ready_i = 1'b0;
                check("rsp_valid after handshake", {31'd0, bus_if.rsp_valid_o}, 32'd0);
                check("cmd_ready after handshake", {31'd0, bus_if.cmd_ready_o}, 32'd1);
                check("no cmd accepted in bp", {31'd0, bus_if.stall_req_o}, 32'd0);
                done = 1'b1;
            end else begin
                bus_if.spr_bus_ack_i = v.spur;
                bus_if.spr_bus_dat_i = 32'hBAD0BAD0;
                if (ps_cyc < 0) begin
                    if (waited == v.stall_dly) begin
                        bus_if.pipe_stalled_i = 1'b1;
                        ps_cyc = cyc;
                    end else begin
                        waited++;
                    end
                end
            end
            if (!done) tick();
        end
        if (!done) check("transfer completion timeout", 32'd0, 32'd1);
    endtask

    initial begin
        vec_t rst_vec;
        //          we    addr      dat           sd  ack rd_val        bp spur exp_dat       err  stb
        vecs[0] = '{1'b1, 16'h0405, 32'hDEADBEEF, 3,  1,  32'h0,        0, 1'b0, 32'h0,        1'b0, 1};
        vecs[1] = '{1'b0, 16'h0405, 32'h0,        2,  2,  32'h12345678, 0, 1'b0, 32'h12345678, 1'b0, 2};
        vecs[2] = '{1'b0, 16'h3000, 32'h0,        1,  0,  32'h77777777, 0, 1'b0, 32'h0,        1'b1, 16};
        vecs[3] = '{1'b0, 16'h0410, 32'h0,        0,  2,  32'hCAFEF00D, 5, 1'b0, 32'hCAFEF00D, 1'b0, 2};
        vecs[4] = '{1'b0, 16'h0801, 32'h0,        10, 3,  32'hA5A55A5A, 0, 1'b1, 32'hA5A55A5A, 1'b0, 3};
        vecs[5] = '{1'b0, 16'h2001, 32'h0,        1,  16, 32'h0F0F1234, 0, 1'b0, 32'h0F0F1234, 1'b0, 16};
        vecs[6] = '{1'b1, 16'h2002, 32'h11223344, 2,  0,  32'h0,        1, 1'b0, 32'h0,        1'b1, 16};
        vecs[7] = '{1'b1, 16'h1234, 32'h55667788, 0,  4,  32'h99999999, 0, 1'b1, 32'h0,        1'b0, 4};
        rst_vec = '{1'b0, 16'h3000, 32'h0, 1, 0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 0};

        rst_n                 = 1'b0;
        bus_if.cmd_valid_i    = 1'b0;
        bus_if.cmd_we_i       = 1'b0;
        bus_if.cmd_addr_i     = 16'h0;
        bus_if.cmd_dat_i      = 32'h0;
        bus_if.rsp_ready_i    = 1'b0;
        bus_if.pipe_stalled_i = 1'b0;
        bus_if.spr_bus_ack_i  = 1'b0;
        bus_if.spr_bus_dat_i  = 32'h0;
        tick();
        tick();
        check("reset cmd_ready", {31'd0, bus_if.cmd_ready_o}, 32'd1);
        check("reset rsp_valid", {31'd0, bus_if.rsp_valid_o}, 32'd0);
        check("reset rsp_err", {31'd0, bus_if.rsp_err_o}, 32'd0);
        check("reset rsp_dat", bus_if.rsp_dat_o, 32'h0);
        check("reset stall_req", {31'd0, bus_if.stall_req_o}, 32'd0);
        check("reset stb", {31'd0, bus_if.spr_bus_stb_o}, 32'd0);
        check("reset we", {31'd0, bus_if.spr_bus_we_o}, 32'd0);
        check("reset addr", {16'd0, bus_if.spr_bus_addr_o}, 32'd0);
        check("reset bus dat", bus_if.spr_bus_dat_o, 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i], 0);
        end

        // Reset pulse in the third strobe cycle of a never-acked read, then a
        // normal GPR write must still complete.
        run_cmd(rst_vec, 3);
        run_cmd(vecs[0], 0);
        check("scoreboard drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mor1kx_spr_initiator_marocchino.md
# mor1kx_spr_initiator_marocchino

SPR-bus initiator for the MAROCCHINO pipeline. It accepts single read/write commands from a host-side agent such as a debug unit, stalls the pipeline, and runs one SPR-bus transfer. The transfer targets the GPR window (addr[15:9]==7'h2) served by the register file, or any other SPR responder. It then returns the read data, or an error on timeout, through a valid/ready response port.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32, SPR data width.
- TIMEOUT_CYCLES, 16, maximum strobe cycles without ack before abort (range 2..255).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  host command present.
- cmd_ready_o  out  1  block can accept a command.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  16  SPR address.
- cmd_dat_i  in  OPTION_OPERAND_WIDTH  write data.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  host consumes response.
- rsp_dat_o  out  OPTION_OPERAND_WIDTH  read data (0 for writes and errors).
- rsp_err_o  out  1  transfer timed out.
- stall_req_o  out  1  request pipeline stall.
- pipe_stalled_i  in  1  pipeline is stalled and drained.
- spr_bus_addr_o  out  16  SPR address.
- spr_bus_stb_o  out  1  transfer strobe.
- spr_bus_we_o  out  1  write enable.
- spr_bus_dat_o  out  OPTION_OPERAND_WIDTH  write data.
- spr_bus_ack_i  in  1  responder acknowledge.
- spr_bus_dat_i  in  OPTION_OPERAND_WIDTH  responder read data.

## Operation
FSM states: IDLE, STALL, GAP, ACCESS, RESP.

- **IDLE**
  - cmd_ready_o=1 in this state only.
  - On cmd_valid_i: register we/addr/dat into the bus output registers, set stall_req_o, go to STALL.
- **STALL**
  - Hold stall_req_o.
  - On pipe_stalled_i, go to GAP.
  - This state has no timeout.
- **GAP**
  - One fixed idle cycle after the stall is confirmed, so the last write-back retires before the bus cycle starts.
  - Set spr_bus_stb_o, clear the timeout counter, go to ACCESS.
- **ACCESS**
  - stb, we, addr and dat are held constant.
  - The counter increments each cycle spr_bus_ack_i=0.
  - On ack:
    - Capture spr_bus_dat_i into rsp_dat_o for reads; load 0 for writes.
    - rsp_err_o=0.
    - Clear stb and stall_req_o, set rsp_valid_o, go to RESP.
  - On counter==TIMEOUT_CYCLES-1 with no ack:
    - Same exit, but rsp_err_o=1 and rsp_dat_o=0.
  - Ack and timeout in the same cycle: ack wins.
- **RESP**
  - Hold rsp_valid_o/rsp_dat_o/rsp_err_o until rsp_ready_i.
  - Then clear rsp_valid_o and go to IDLE.
- spr_bus_ack_i outside ACCESS is ignored.
- pipe_stalled_i dropping in GAP or ACCESS does not abort the transfer.
- Only one command is outstanding at a time. No pipelining of commands.

## Timing
- Reset (asynchronous, rst_n=0):
  - State = IDLE; all outputs 0 except cmd_ready_o=1.
  - Reset asserted mid-transfer drops stb and stall_req_o immediately; no response is produced.
- Accept cycle T (cmd_valid_i & cmd_ready_o): stall_req_o=1 from T+1.
- pipe_stalled_i sampled high at cycle S: GAP is S+1, and stb is first high at S+2.
- All outputs are registered; stb falls the cycle after ack is sampled.
  - Write to GPR window: responder acks in the first stb cycle, so stb is high exactly 1 cycle.
  - Read from GPR window: ack comes in the second stb cycle, so stb is high 2 cycles.
- rsp_valid_o rises the cycle after ack/timeout. stall_req_o falls in the same cycle.
- Timeout: stb is high exactly TIMEOUT_CYCLES cycles, then rsp_valid_o with rsp_err_o=1.
- Minimum command-to-command spacing: rsp_ready_i high at R gives cmd_ready_o=1 at R+1.

## Test plan
- **GPR write.** cmd we=1, addr=0x0405, dat=0xDEADBEEF; pipe_stalled_i 3 cycles after stall_req_o; responder acks in the first stb cycle.
  - Bus shows addr 0x0405, we=1, dat 0xDEADBEEF, stb high 1 cycle.
  - Response: rsp_err_o=0, rsp_dat_o=0.
- **GPR read.** cmd we=0, addr=0x0405; responder returns 0x12345678 with ack in the second stb cycle.
  - stb high 2 cycles; rsp_dat_o=0x12345678.
- **Timeout.** Read of addr 0x3000 with ack never asserted, TIMEOUT_CYCLES=16.
  - stb high exactly 16 cycles; rsp_err_o=1, rsp_dat_o=0; stall_req_o released.
- **Backpressure.** rsp_ready_i held low 5 cycles after a read.
  - rsp_valid_o and rsp_dat_o stable for all 5 cycles; cmd_ready_o=0 throughout; a new cmd_valid_i is not accepted until after the handshake.
- **Ordering and ignored ack.** pipe_stalled_i delayed 10 cycles, plus a spurious ack during STALL.
  - No stb before pipe_stalled_i+2 cycles; the spurious ack is ignored.
- **Reset mid-transfer.** rst_n pulsed low during ACCESS.
  - stb, stall_req_o and rsp_valid_o go to 0 asynchronously; cmd_ready_o=1 after release; the next write completes normally.
